// File: rtl/uart_rx_display_ctrl_pkg.sv
// rtl/uart_rx_display_ctrl_pkg.sv - shared types and widths for the UART RX display controller
package uart_pkg;
  localparam int LP_DATA_W   = 8;
  localparam int LP_NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    LATCH = 2'd2
  } disp_state_t;
endpackage

// File: rtl/uart_rx_display_ctrl_button_debounce.sv
// rtl/uart_rx_display_ctrl_button_debounce.sv - 2-flop synchronizer, stable-count debouncer, rising-edge press pulse
module button_debounce #(
  parameter int P_DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);
  localparam int LP_CNT_W = $clog2(P_DEBOUNCE_CYCLES + 1);
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                level_q, level_d;
  logic                level_prev_q, level_prev_d;
  logic [LP_CNT_W-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronized input disagrees with the
  // accepted level; agreement (any toggle back) restarts it from zero.
  always_comb begin
    sync1_d      = btn_raw;
    sync2_d      = sync1_q;
    level_d      = level_q;
    level_prev_d = level_q;
    cnt_d        = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == LP_CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      cnt_q        <= cnt_d;
    end
  end

  assign press = level_q & ~level_prev_q;
endmodule

// File: rtl/uart_rx_display_ctrl.sv
// rtl/uart_rx_display_ctrl.sv - pops one RX FIFO byte per press onto the hex display; DISPLAY_AUTO_ADVANCE_EN adds a periodic press
module uart_rx_display_ctrl
  import uart_pkg::*;
#(
  parameter int P_DEBOUNCE_CYCLES = 16,
  parameter int P_AUTO_CYCLES     = 500000000
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   display_next,
  input  logic                   fifo_empty,
  input  logic [LP_DATA_W-1:0]   fifo_rd_data,
  input  logic                   rx_frame_error,
  output logic                   fifo_rd_en,
  output logic [LP_NIBBLE_W-1:0] data_out_msd,
  output logic [LP_NIBBLE_W-1:0] data_out_lsd,
  output logic                   error,
  output logic                   disp_valid
);
  logic btn_press;
  logic auto_press;
  logic press;

  button_debounce #(
    .P_DEBOUNCE_CYCLES(P_DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (CLK),
    .reset  (reset),
    .btn_raw(display_next),
    .press  (btn_press)
  );

`ifdef DISPLAY_AUTO_ADVANCE_EN
  localparam int LP_AUTO_W = $clog2(P_AUTO_CYCLES + 1);
  localparam logic [LP_AUTO_W-1:0] LP_AUTO_LAST = LP_AUTO_W'(P_AUTO_CYCLES - 1);

  logic [LP_AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  always_comb begin
    auto_press = 1'b0;
    auto_cnt_d = auto_cnt_q + 1'b1;
    if (btn_press) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == LP_AUTO_LAST) begin
      auto_press = 1'b1;
      auto_cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  // Without auto-advance the period has no meaning; only the button advances.
  assign auto_press = 1'b0 && (P_AUTO_CYCLES > 0);
`endif

  assign press = btn_press | auto_press;

  disp_state_t          state_q, state_d;
  logic [LP_DATA_W-1:0] disp_byte_q, disp_byte_d;
  logic                 disp_valid_q, disp_valid_d;
  logic                 error_q, error_d;

  always_comb begin
    state_d      = state_q;
    disp_byte_d  = disp_byte_q;
    disp_valid_d = disp_valid_q;
    fifo_rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (press && !fifo_empty) begin
          state_d = POP;
        end
      end
      POP: begin
        fifo_rd_en = 1'b1;
        state_d    = LATCH;
      end
      LATCH: begin
        disp_byte_d  = fifo_rd_data;
        disp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A frame error seen in the latch cycle still wins over the clear.
    error_d = rx_frame_error | (error_q & (state_q != LATCH));
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      disp_byte_q  <= '0;
      disp_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      disp_byte_q  <= disp_byte_d;
      disp_valid_q <= disp_valid_d;
      error_q      <= error_d;
    end
  end

  assign data_out_msd = disp_byte_q[LP_DATA_W-1:LP_NIBBLE_W];
  assign data_out_lsd = disp_byte_q[LP_NIBBLE_W-1:0];
  assign error        = error_q;
  assign disp_valid   = disp_valid_q;
endmodule

// File: tb/tb_uart_rx_display_ctrl.sv
// tb/tb_uart_rx_display_ctrl.sv - self-checking bench for uart_rx_display_ctrl
module tb_uart_rx_display_ctrl;
  localparam int P_DB   = 16;
  localparam int P_AUTO = 50;

  logic       CLK = 1'b0;
  logic       reset;
  logic       display_next;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       rx_frame_error;
  logic       fifo_rd_en;
  logic [3:0] data_out_msd;
  logic [3:0] data_out_lsd;
  logic       error;
  logic       disp_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int pop_cnt = 0;
  logic [7:0] fifo_q[$];

  uart_rx_display_ctrl #(
    .P_DEBOUNCE_CYCLES(P_DB),
    .P_AUTO_CYCLES    (P_AUTO)
  ) dut (
    .CLK           (CLK),
    .reset         (reset),
    .display_next  (display_next),
    .fifo_empty    (fifo_empty),
    .fifo_rd_data  (fifo_rd_data),
    .rx_frame_error(rx_frame_error),
    .fifo_rd_en    (fifo_rd_en),
    .data_out_msd  (data_out_msd),
    .data_out_lsd  (data_out_lsd),
    .error         (error),
    .disp_valid    (disp_valid)
  );

  always #5 CLK = ~CLK;

  // FIFO model: head data appears the cycle after a pop request.
  always @(posedge CLK) begin
    if (fifo_rd_en === 1'b1 && fifo_q.size() != 0) begin
      fifo_rd_data <= fifo_q.pop_front();
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  always @(negedge CLK) begin
    if (fifo_rd_en === 1'b1) pop_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    bit         empty;
    bit         err_pulse;
    logic [3:0] e_msd;
    logic [3:0] e_lsd;
    bit         e_err;
    bit         e_valid;
    int         e_pops;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_err();
    @(posedge CLK); #1 rx_frame_error = 1'b1;
    @(posedge CLK); #1 rx_frame_error = 1'b0;
    wait_cycles(2);
  endtask

  task automatic wait_rd(output int found);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (fifo_rd_en === 1'b1) begin
        found = 1;
        break;
      end
    end
  endtask

  task automatic run_case(input logic [7:0] data, input bit empty, input bit errp,
                          input int hold, input int bounces, output int pops);
    int p0;
    int h;
    if (!empty) fifo_q.push_back(data);
    wait_cycles(2);
    if (errp) begin
      pulse_err();
      check("err_set", error, 1);
    end
    p0 = pop_cnt;
    for (int b = 0; b < bounces; b++) begin
      h = $urandom_range(2, P_DB - 3);
      display_next = 1'b1; wait_cycles(h);
      display_next = 1'b0; wait_cycles(h);
    end
    display_next = 1'b1; wait_cycles(hold);
    display_next = 1'b0; wait_cycles(P_DB + 8);
    pops = pop_cnt - p0;
  endtask

  initial begin
    int pops, found, rd_idx, npulse;
    logic [7:0] cap, exp_byte, d;
    bit exp_err, emp, ep;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 4'hA, 4'h5, 1'b0, 1'b1, 1};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 4'h3, 4'hC, 1'b0, 1'b1, 1};
    vecs[2] = '{8'h77, 1'b1, 1'b0, 4'h3, 4'hC, 1'b0, 1'b1, 0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b1, 1};
    vecs[4] = '{8'h55, 1'b1, 1'b1, 4'h0, 4'h1, 1'b1, 1'b1, 0};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b1, 1};

    reset = 1'b1; display_next = 1'b0; rx_frame_error = 1'b0;
    wait_cycles(3);
    reset = 1'b0;
    wait_cycles(1);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_msd", data_out_msd, 0);
    check("rst_lsd", data_out_lsd, 0);
    check("rst_err", error, 0);
    check("rst_valid", disp_valid, 0);

`ifdef DISPLAY_AUTO_ADVANCE_EN
    for (int k = 0; k < 4; k++) fifo_q.push_back(8'(k));
    begin
      int idx[$];
      int k2 = 0;
      for (int i = 1; i <= 300; i++) begin
        @(negedge CLK);
        if (fifo_rd_en === 1'b1) idx.push_back(i);
        if (idx.size() > k2 && i == idx[k2] + 2) begin
          check("auto_step", {data_out_msd, data_out_lsd}, k2);
          k2++;
        end
      end
      check("auto_pops", idx.size(), 4);
      for (int k = 1; k < idx.size(); k++) check("auto_period", idx[k] - idx[k-1], P_AUTO);
      check("auto_hold", {data_out_msd, data_out_lsd}, 8'h03);
    end
`else
    // Latency and single-pulse check on a clean 100-cycle press.
    fifo_q.push_back(8'h5A);
    wait_cycles(2);
    rd_idx = -1; npulse = 0; cap = 8'hxx;
    display_next = 1'b1;
    for (int k = 1; k <= 100 + P_DB + 8; k++) begin
      if (k == 101) display_next = 1'b0;
      @(negedge CLK);
      if (fifo_rd_en === 1'b1) begin
        npulse++;
        if (rd_idx < 0) rd_idx = k;
      end
      if (rd_idx > 0 && k == rd_idx + 2) cap = {data_out_msd, data_out_lsd};
    end
    check("press_latency", rd_idx, P_DB + 3);
    check("one_pulse", npulse, 1);
    check("disp_at_press2", cap, 8'h5A);

    for (int i = 0; i < 6; i++) begin
      run_case(vecs[i].data, vecs[i].empty, vecs[i].err_pulse, 40, 0, pops);
      check("vec_msd", data_out_msd, vecs[i].e_msd);
      check("vec_lsd", data_out_lsd, vecs[i].e_lsd);
      check("vec_err", error, vecs[i].e_err);
      check("vec_valid", disp_valid, vecs[i].e_valid);
      check("vec_pops", pops, vecs[i].e_pops);
    end

    // Error set before the press is cleared by LATCH.
    pulse_err();
    fifo_q.push_back(8'h01);
    wait_cycles(2);
    display_next = 1'b1;
    wait_rd(found);
    check("errA_rd", found, 1);
    check("errA_pop", error, 1);
    wait_cycles(2);
    check("errA_clr", error, 0);
    check("errA_disp", {data_out_msd, data_out_lsd}, 8'h01);
    display_next = 1'b0; wait_cycles(P_DB + 8);

    // Error pulse coincident with LATCH survives.
    fifo_q.push_back(8'h02);
    wait_cycles(2);
    display_next = 1'b1;
    wait_rd(found);
    check("errB_rd", found, 1);
    @(posedge CLK); #1 rx_frame_error = 1'b1;
    @(posedge CLK); #1 rx_frame_error = 1'b0;
    wait_cycles(2);
    check("errB_err", error, 1);
    check("errB_disp", {data_out_msd, data_out_lsd}, 8'h02);
    display_next = 1'b0; wait_cycles(P_DB + 8);

    // Bounce: toggle every 5 cycles for 60 cycles, then stable high.
    fifo_q.push_back(8'h5A); fifo_q.push_back(8'h6B);
    wait_cycles(2);
    pops = pop_cnt;
    for (int i = 0; i < 12; i++) begin
      display_next = ~display_next;
      wait_cycles(5);
    end
    display_next = 1'b1; wait_cycles(40);
    display_next = 1'b0; wait_cycles(40);
    check("bounce_pops", pop_cnt - pops, 1);
    check("bounce_disp", {data_out_msd, data_out_lsd}, 8'h5A);
    check("bounce_err", error, 0);
    fifo_q.delete();
    wait_cycles(2);

    exp_byte = 8'h5A; exp_err = 1'b0;
    for (int it = 0; it < 12; it++) begin
      d   = 8'($urandom);
      emp = ($urandom_range(0, 3) == 0);
      ep  = ($urandom_range(0, 2) == 0);
      run_case(d, emp, ep, P_DB + 10 + $urandom_range(0, 40), $urandom_range(0, 3), pops);
      if (ep) exp_err = 1'b1;
      if (!emp) begin
        exp_byte = d;
        exp_err  = 1'b0;
      end
      check("rnd_msd", data_out_msd, exp_byte[7:4]);
      check("rnd_lsd", data_out_lsd, exp_byte[3:0]);
      check("rnd_err", error, exp_err);
      check("rnd_valid", disp_valid, 1);
      check("rnd_pops", pops, emp ? 0 : 1);
    end

    // Reset while fifo_rd_en is asserted.
    pulse_err();
    fifo_q.push_back(8'h99);
    wait_cycles(2);
    display_next = 1'b1;
    wait_rd(found);
    check("rstpop_rd", found, 1);
    reset = 1'b1; display_next = 1'b0;
    @(negedge CLK);
    check("rstpop_rd_en", fifo_rd_en, 0);
    check("rstpop_disp", {data_out_msd, data_out_lsd}, 8'h00);
    check("rstpop_err", error, 0);
    check("rstpop_valid", disp_valid, 0);
    reset = 1'b0;
    wait_cycles(2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
